// File: rtl/food_spawner.sv
// food_spawner: multi-slot food placement engine for the snake game.
// Draws grid-aligned x/y candidates from the shared random source and
// range-checks them against the playfield. A failed candidate is redrawn
// up to MAX_RETRY times; after that the last candidate is clamped and
// committed with spawn_fault. Eats clear a slot's live flag only.
// Optional feature macro: FOOD_OVERLAP_CHECK_EN. When it is defined, a
// candidate that lands on another live slot is also rejected.
module food_spawner #(
  parameter int N_FOOD     = 4,
  parameter int COORD_W    = 10,
  parameter int RAND_W     = 9,
  parameter int GRID_SHIFT = 0,
  parameter int X_MIN      = 16,
  parameter int X_MAX      = 623,
  parameter int Y_MIN      = 16,
  parameter int Y_MAX      = 463,
  parameter int MAX_RETRY  = 3,
  parameter int RESET_X    = 300,
  parameter int RESET_Y    = 300,
  parameter int SLOT_W     = (N_FOOD > 1) ? $clog2(N_FOOD) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [RAND_W-1:0]           rand_num,
  input  logic                        spawn_req,
  input  logic [SLOT_W-1:0]           spawn_slot,
  input  logic                        eat_valid,
  input  logic [SLOT_W-1:0]           eat_slot,
  output logic [N_FOOD*COORD_W-1:0]   food_x,
  output logic [N_FOOD*COORD_W-1:0]   food_y,
  output logic [N_FOOD-1:0]           food_valid,
  output logic                        busy,
  output logic                        spawn_done,
  output logic                        spawn_fault
);

  localparam int                WIDE_W      = (RAND_W + GRID_SHIFT > COORD_W) ? (RAND_W + GRID_SHIFT) : COORD_W;
  localparam logic [COORD_W-1:0] X_MIN_C    = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0] X_MAX_C    = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_MIN_C    = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0] Y_MAX_C    = COORD_W'(Y_MAX);
  localparam logic [3:0]         MAX_RETRY_C = 4'(MAX_RETRY);
  localparam logic [SLOT_W:0]    N_FOOD_C   = (SLOT_W + 1)'(N_FOOD);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAW_X = 2'd1,
    S_DRAW_Y = 2'd2,
    S_CHECK  = 2'd3
  } state_t;

  // Saturate one axis into [lo, hi]; identity for in-range values.
  function automatic logic [COORD_W-1:0] clamp_axis(input logic [COORD_W-1:0] v,
                                                    input logic [COORD_W-1:0] lo,
                                                    input logic [COORD_W-1:0] hi);
    logic [COORD_W-1:0] r;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t                      state_r, state_nx_s;
  logic [3:0]                  retry_r, retry_nx_s;
  logic [SLOT_W-1:0]           slot_r;
  logic [COORD_W-1:0]          cand_x_r, cand_y_r;
  logic [N_FOOD*COORD_W-1:0]   food_x_r, food_y_r;
  logic [N_FOOD-1:0]           food_valid_r;
  logic                        busy_r, spawn_done_r, spawn_fault_r;

  logic [COORD_W-1:0]          aligned_s;
  logic [COORD_W-1:0]          clamp_x_s, clamp_y_s;
  logic                        slot_ok_s, in_range_s, overlap_s, pass_s;
  logic                        commit_s, fault_s;

  assign aligned_s  = COORD_W'(WIDE_W'(rand_num) << GRID_SHIFT);
  assign slot_ok_s  = ({1'b0, spawn_slot} < N_FOOD_C);
  assign in_range_s = (cand_x_r >= X_MIN_C) && (cand_x_r <= X_MAX_C) &&
                      (cand_y_r >= Y_MIN_C) && (cand_y_r <= Y_MAX_C);
  assign clamp_x_s  = clamp_axis(cand_x_r, X_MIN_C, X_MAX_C);
  assign clamp_y_s  = clamp_axis(cand_y_r, Y_MIN_C, Y_MAX_C);
  assign pass_s     = in_range_s && !overlap_s;

`ifdef FOOD_OVERLAP_CHECK_EN
  // Flag a candidate that sits exactly on another live slot.
  always_comb begin
    overlap_s = 1'b0;
    for (int i = 0; i < N_FOOD; i++) begin
      if (food_valid_r[i] && (slot_r != SLOT_W'(i)) &&
          (food_x_r[i*COORD_W +: COORD_W] == cand_x_r) &&
          (food_y_r[i*COORD_W +: COORD_W] == cand_y_r)) begin
        overlap_s = 1'b1;
      end else begin
        overlap_s = overlap_s;
      end
    end
  end
`else
  assign overlap_s = 1'b0;
`endif

  // Next-state, retry bookkeeping and commit/fault decisions.
  always_comb begin
    state_nx_s = state_r;
    retry_nx_s = retry_r;
    commit_s   = 1'b0;
    fault_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (spawn_req && slot_ok_s) begin
          state_nx_s = S_DRAW_X;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_DRAW_X: state_nx_s = S_DRAW_Y;
      S_DRAW_Y: state_nx_s = S_CHECK;
      S_CHECK: begin
        if (pass_s) begin
          commit_s   = 1'b1;
          retry_nx_s = 4'd0;
          state_nx_s = S_IDLE;
        end else if (retry_r < MAX_RETRY_C) begin
          retry_nx_s = retry_r + 4'd1;
          state_nx_s = S_DRAW_X;
        end else begin
          commit_s   = 1'b1;
          fault_s    = 1'b1;
          retry_nx_s = 4'd0;
          state_nx_s = S_IDLE;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
        retry_nx_s = 4'd0;
      end
    endcase
  end

  // Control registers: state, retry count and the registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      retry_r       <= 4'd0;
      busy_r        <= 1'b0;
      spawn_done_r  <= 1'b0;
      spawn_fault_r <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      retry_r       <= retry_nx_s;
      busy_r        <= (state_nx_s != S_IDLE);
      spawn_done_r  <= commit_s;
      spawn_fault_r <= fault_s;
    end
  end

  // Candidate capture: target slot on accept, one axis per draw state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_r   <= {SLOT_W{1'b0}};
      cand_x_r <= {COORD_W{1'b0}};
      cand_y_r <= {COORD_W{1'b0}};
    end else begin
      if ((state_r == S_IDLE) && spawn_req && slot_ok_s) begin
        slot_r <= spawn_slot;
      end
      if (state_r == S_DRAW_X) begin
        cand_x_r <= aligned_s;
      end
      if (state_r == S_DRAW_Y) begin
        cand_y_r <= aligned_s;
      end
    end
  end

  // Slot table: a commit writes position and sets valid and beats a same-slot eat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_FOOD; i++) begin
        food_x_r[i*COORD_W +: COORD_W] <= (i == 0) ? COORD_W'(RESET_X) : {COORD_W{1'b0}};
        food_y_r[i*COORD_W +: COORD_W] <= (i == 0) ? COORD_W'(RESET_Y) : {COORD_W{1'b0}};
      end
      food_valid_r <= N_FOOD'(1);
    end else begin
      for (int i = 0; i < N_FOOD; i++) begin
        if (commit_s && (slot_r == SLOT_W'(i))) begin
          food_x_r[i*COORD_W +: COORD_W] <= clamp_x_s;
          food_y_r[i*COORD_W +: COORD_W] <= clamp_y_s;
          food_valid_r[i]                <= 1'b1;
        end else if (eat_valid && (eat_slot == SLOT_W'(i))) begin
          food_valid_r[i] <= 1'b0;
        end
      end
    end
  end

  assign food_x      = food_x_r;
  assign food_y      = food_y_r;
  assign food_valid  = food_valid_r;
  assign busy        = busy_r;
  assign spawn_done  = spawn_done_r;
  assign spawn_fault = spawn_fault_r;

endmodule

// File: tb/tb_food_spawner.sv
// tb_food_spawner: directed scoreboard bench for food_spawner.
// N_FOOD is 3 so that slot index 3 is encodable but out of range.
module tb_food_spawner;

  localparam int N_FOOD  = 3;
  localparam int COORD_W = 10;
  localparam int RAND_W  = 9;
  localparam int SLOT_W  = 2;

  logic                       clk;
  logic                       rst_n;
  logic [RAND_W-1:0]          rand_num;
  logic                       spawn_req;
  logic [SLOT_W-1:0]          spawn_slot;
  logic                       eat_valid;
  logic [SLOT_W-1:0]          eat_slot;
  logic [N_FOOD*COORD_W-1:0]  food_x;
  logic [N_FOOD*COORD_W-1:0]  food_y;
  logic [N_FOOD-1:0]          food_valid;
  logic                       busy;
  logic                       spawn_done;
  logic                       spawn_fault;

  food_spawner #(.N_FOOD(N_FOOD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rand_num    (rand_num),
    .spawn_req   (spawn_req),
    .spawn_slot  (spawn_slot),
    .eat_valid   (eat_valid),
    .eat_slot    (eat_slot),
    .food_x      (food_x),
    .food_y      (food_y),
    .food_valid  (food_valid),
    .busy        (busy),
    .spawn_done  (spawn_done),
    .spawn_fault (spawn_fault)
  );

  typedef struct {
    int slot;
    int x;
    int y;
    bit fault;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   draws [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to check commit latency.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  function automatic int fx(input int s);
    return int'(food_x[s*COORD_W +: COORD_W]);
  endfunction

  function automatic int fy(input int s);
    return int'(food_y[s*COORD_W +: COORD_W]);
  endfunction

  // Monitor: every spawn_done pops one expected commit and compares it.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && spawn_done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("commit_x",     fx(e.slot), e.x);
        chk("commit_y",     fy(e.slot), e.y);
        chk("commit_valid", int'(food_valid[e.slot]), 1);
        chk("commit_fault", int'(spawn_fault), int'(e.fault));
        chk("commit_cycle", cyc, e.cyc);
        chk("commit_busy",  int'(busy), 0);
      end
    end
    if (rst_n && spawn_fault && !spawn_done) begin
      chk("fault_without_done", 1, 0);
    end
  end

  task automatic set_draws(input int a, input int b, input int c, input int d,
                           input int e, input int f, input int g, input int h);
    draws = '{a, b, c, d, e, f, g, h};
  endtask

  // Issue one request, feed draws for up to four attempts, push expectation.
  // k is the attempt (0-based) that commits; eat_cmt eats the slot on that commit edge.
  task automatic run_spawn(input int slot, input int ex, input int ey,
                           input bit ef, input int k, input bit eat_cmt);
    exp_t e;
    @(negedge clk);
    spawn_req  = 1'b1;
    spawn_slot = SLOT_W'(slot);
    e.slot  = slot;
    e.x     = ex;
    e.y     = ey;
    e.fault = ef;
    e.cyc   = cyc + 1 + 3 + 3 * k;
    sb_q.push_back(e);
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      spawn_req = 1'b0;
      eat_valid = 1'b0;
      rand_num  = RAND_W'(draws[2*a]);
      @(negedge clk);
      rand_num  = RAND_W'(draws[2*a+1]);
      @(negedge clk);
      if (eat_cmt && (a == k)) begin
        eat_valid = 1'b1;
        eat_slot  = SLOT_W'(slot);
      end
    end
    @(negedge clk);
    eat_valid = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    rand_num   = '0;
    spawn_req  = 1'b0;
    spawn_slot = '0;
    eat_valid  = 1'b0;
    eat_slot   = '0;
    repeat (3) @(negedge clk);
    chk("rst_x0",    fx(0), 300);
    chk("rst_y0",    fy(0), 300);
    chk("rst_x1",    fx(1), 0);
    chk("rst_valid", int'(food_valid), 1);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_done",  int'(spawn_done), 0);
    chk("rst_fault", int'(spawn_fault), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Candidate on top of slot 0 at (300,300).
    set_draws(300, 300, 120, 130, 120, 130, 120, 130);
`ifdef FOOD_OVERLAP_CHECK_EN
    run_spawn(1, 120, 130, 1'b0, 1, 1'b0);
`else
    run_spawn(1, 300, 300, 1'b0, 0, 1'b0);
`endif

    // First-try spawn.
    set_draws(100, 200, 0, 0, 0, 0, 0, 0);
    run_spawn(2, 100, 200, 1'b0, 0, 1'b0);

    // x=5 rejected, then (40,60) accepted; overwrites a live slot.
    set_draws(5, 50, 40, 60, 0, 0, 0, 0);
    run_spawn(2, 40, 60, 1'b0, 1, 1'b0);

    // Every draw low: clamp to minimum after exhausting retries.
    set_draws(5, 5, 5, 5, 5, 5, 5, 5);
    run_spawn(0, 16, 16, 1'b1, 3, 1'b0);

    // y always above Y_MAX: x kept, y clamped to 463.
    set_draws(500, 500, 500, 500, 500, 500, 500, 500);
    run_spawn(1, 500, 463, 1'b1, 3, 1'b0);

    // Boundaries: x=15 fails, then (16,463) is exactly legal.
    set_draws(15, 463, 16, 463, 0, 0, 0, 0);
    run_spawn(0, 16, 463, 1'b0, 1, 1'b0);

    // Eat on the commit edge of the same slot: commit wins.
    set_draws(100, 200, 0, 0, 0, 0, 0, 0);
    run_spawn(1, 100, 200, 1'b0, 0, 1'b1);
    chk("eat_vs_commit_valid", int'(food_valid), 7);

    // Plain eat of slot 0: valid drops, position kept.
    @(negedge clk);
    eat_valid = 1'b1;
    eat_slot  = 2'd0;
    @(negedge clk);
    eat_valid = 1'b0;
    chk("eat0_valid", int'(food_valid), 6);
    chk("eat0_x_kept", fx(0), 16);

    // Eat of an out-of-range slot is ignored.
    eat_valid = 1'b1;
    eat_slot  = 2'd3;
    @(negedge clk);
    eat_valid = 1'b0;
    chk("eat_oob_valid", int'(food_valid), 6);

    // Out-of-range spawn slot is ignored.
    spawn_req  = 1'b1;
    spawn_slot = 2'd3;
    @(negedge clk);
    spawn_req  = 1'b0;
    chk("oob_req_busy", int'(busy), 0);
    repeat (4) @(negedge clk);
    chk("oob_req_busy_late", int'(busy), 0);

    // Reset asserted while in DRAW_Y.
    spawn_req  = 1'b1;
    spawn_slot = 2'd2;
    @(negedge clk);
    spawn_req  = 1'b0;
    rand_num   = 9'd77;
    @(negedge clk);
    rand_num   = 9'd88;
    chk("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_x0",    fx(0), 300);
    chk("midrst_y0",    fy(0), 300);
    chk("midrst_x2",    fx(2), 0);
    chk("midrst_valid", int'(food_valid), 1);
    chk("midrst_busy",  int'(busy), 0);
    chk("midrst_done",  int'(spawn_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_draws(100, 200, 0, 0, 0, 0, 0, 0);
    run_spawn(2, 100, 200, 1'b0, 0, 1'b0);
    chk("post_rst_valid", int'(food_valid), 5);

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 20 && sb_q.size() != 0; w++) begin
      @(negedge clk);
    end
    chk("sb_drain", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
